// File: rtl/ow_temp_responder.sv
// DS18B20-style 1-wire responder: reset/presence, SKIP ROM, CONVERT T, READ SCRATCHPAD.
// Define OW_CRC_EN to send the Dallas CRC-8 as scratchpad byte 8; otherwise byte 8 is 0x00.
module ow_temp_responder #(
  parameter int CLK_PER_US = 48,
  parameter int RST_MIN_US = 400,
  parameter int PD_WAIT_US = 30,
  parameter int PD_LOW_US  = 120,
  parameter int SAMPLE_US  = 30,
  parameter int TX_LOW_US  = 30,
  parameter int CONV_US    = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_owr,
  output logic        o_owr,
  input  logic [15:0] i_temp,
  output logic        o_busy,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_stb
);
  localparam int RST_CYC  = RST_MIN_US * CLK_PER_US;
  localparam int PDW_CYC  = PD_WAIT_US * CLK_PER_US;
  localparam int PDL_CYC  = PD_LOW_US * CLK_PER_US;
  localparam int SMP_CYC  = SAMPLE_US * CLK_PER_US;
  localparam int TXL_CYC  = TX_LOW_US * CLK_PER_US;
  localparam int CONV_CYC = CONV_US * CLK_PER_US;
  localparam int M1   = (PDL_CYC > PDW_CYC) ? PDL_CYC : PDW_CYC;
  localparam int M2   = (M1 > SMP_CYC) ? M1 : SMP_CYC;
  localparam int TMAX = (M2 > TXL_CYC) ? M2 : TXL_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(RST_CYC + 1);
  localparam int CW   = $clog2(CONV_CYC + 1);
  localparam logic [TW-1:0] PDW_END  = TW'(PDW_CYC - 1);
  localparam logic [TW-1:0] PDL_END  = TW'(PDL_CYC - 1);
  localparam logic [TW-1:0] SMP_END  = TW'(SMP_CYC - 1);
  localparam logic [TW-1:0] TXL_END  = TW'(TXL_CYC - 1);
  localparam logic [RW-1:0] RST_HIT  = RW'(RST_CYC - 1);
  localparam logic [RW-1:0] RST_SAT  = RW'(RST_CYC);
  localparam logic [CW-1:0] CONV_END = CW'(CONV_CYC - 1);
  localparam logic [7:0] CMD_SKIP = 8'hCC;
  localparam logic [7:0] CMD_CONV = 8'h44;
  localparam logic [7:0] CMD_READ = 8'hBE;

  typedef enum logic [3:0] {
    S_IDLE, S_RST_WAIT, S_PD_WAIT, S_PD_LOW, S_ROM_RX, S_FN_RX, S_POLL, S_TX, S_HALT
  } state_t;

  state_t r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic          r_prev, r_owr, r_slot, r_busy, r_cmd_stb;
  logic [RW-1:0] r_lo;
  logic [TW-1:0] r_cnt;
  logic [CW-1:0] r_conv;
  logic [6:0]    r_bit;
  logic [7:0]    r_sr, r_cmd;
  logic [63:0]   r_pad;
  logic [15:0]   r_temp;

  logic w_line, w_fall, w_rise, w_rst_det, w_rx, w_txs, w_start, w_end;
  logic w_rx_done, w_cmd_stb, w_tx_load, w_txb, w_crc_bit;
  logic [7:0] w_byte;

  assign w_line    = r_sync[1];
  assign w_fall    = r_prev & ~w_line;
  assign w_rise    = ~r_prev & w_line;
  // Our own pull-down must never look like a master reset pulse.
  assign w_rst_det = ~w_line & ~r_owr & (r_lo == RST_HIT);
  assign w_rx      = (r_state == S_ROM_RX) | (r_state == S_FN_RX);
  assign w_txs     = (r_state == S_POLL) | (r_state == S_TX);
  assign w_start   = w_fall & ~r_slot & ~r_owr & (w_rx | w_txs);
  assign w_end     = r_slot & ((~r_owr & (r_cnt == SMP_END)) | (r_owr & (r_cnt == TXL_END)));
  assign w_byte    = {w_line, r_sr[7:1]};
  assign w_rx_done = w_rx & w_end & (r_bit[2:0] == 3'd7);
  assign w_cmd_stb = (r_state == S_FN_RX) & w_rx_done;
  assign w_tx_load = ~w_rst_det & (r_state != S_TX) & (w_state_nxt == S_TX);

  always_comb begin
    w_txb = r_pad[0];
    if (r_state == S_POLL) w_txb = ~r_busy;
    else if (r_bit[6])     w_txb = w_crc_bit;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_rst_det) w_state_nxt = S_RST_WAIT;
    else begin
      case (r_state)
        S_RST_WAIT: if (w_rise) w_state_nxt = S_PD_WAIT;
        S_PD_WAIT:  if (r_cnt == PDW_END) w_state_nxt = S_PD_LOW;
        S_PD_LOW:   if (r_cnt == PDL_END) w_state_nxt = S_ROM_RX;
        S_ROM_RX:   if (w_rx_done) w_state_nxt = (w_byte == CMD_SKIP) ? S_FN_RX : S_HALT;
        S_FN_RX: if (w_rx_done) begin
          if (w_byte == CMD_CONV)      w_state_nxt = S_POLL;
          else if (w_byte == CMD_READ) w_state_nxt = S_TX;
          else                         w_state_nxt = S_HALT;
        end
        S_TX:       if (w_end && r_bit == 7'd71) w_state_nxt = S_HALT;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;  r_prev <= 1'b1;  r_lo <= '0;  r_cnt <= '0;
      r_slot <= 1'b0;   r_owr <= 1'b0;   r_bit <= '0; r_sr <= '0;
      r_pad <= '0;      r_cmd <= '0;     r_cmd_stb <= 1'b0;
      r_busy <= 1'b0;   r_conv <= '0;    r_temp <= 16'h0550;
    end else begin
      r_sync <= {r_sync[0], i_owr};
      r_prev <= r_sync[1];
      if (~w_line & ~r_owr) begin
        if (r_lo != RST_SAT) r_lo <= r_lo + 1'b1;
      end else r_lo <= '0;

      r_cmd_stb <= w_cmd_stb;
      if (w_cmd_stb) r_cmd <= w_byte;
      // Conversion timer is independent of the line and survives a 1-wire reset.
      if (w_cmd_stb && w_byte == CMD_CONV) begin
        r_busy <= 1'b1;
        r_conv <= '0;
      end else if (r_busy) begin
        if (r_conv == CONV_END) begin
          r_busy <= 1'b0;
          r_temp <= i_temp;
        end else r_conv <= r_conv + 1'b1;
      end

      if (w_rst_det) begin
        r_owr <= 1'b0; r_slot <= 1'b0; r_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
        r_cnt <= '0; r_slot <= 1'b0; r_bit <= '0;
        r_owr <= (w_state_nxt == S_PD_LOW);
        if (w_tx_load) r_pad <= {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, r_temp};
      end else if (r_state == S_PD_WAIT || r_state == S_PD_LOW) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_start) begin
        r_slot <= 1'b1;
        r_cnt  <= '0;
        r_owr  <= w_txs & ~w_txb;
      end else if (w_end) begin
        r_slot <= 1'b0;
        r_owr  <= 1'b0;
        r_bit  <= r_bit + 1'b1;
        if (w_rx) r_sr <= w_byte;
        if (r_state == S_TX) r_pad <= {1'b0, r_pad[63:1]};
      end else if (r_slot) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef OW_CRC_EN
  logic [7:0] r_crc;
  logic       w_crc_fb;
  assign w_crc_fb  = r_crc[0] ^ r_pad[0];
  assign w_crc_bit = r_crc[r_bit[2:0]];
  // CRC follows the bits of bytes 0-7 as they leave, ready for byte 8.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_crc <= '0;
    else if (w_tx_load) r_crc <= '0;
    else if (!w_rst_det && r_state == S_TX && w_end && !r_bit[6])
      r_crc <= {1'b0, r_crc[7:1]} ^ (w_crc_fb ? 8'h8C : 8'h00);
  end
`else
  assign w_crc_bit = 1'b0;
`endif

  assign o_owr     = r_owr;
  assign o_busy    = r_busy;
  assign o_cmd     = r_cmd;
  assign o_cmd_stb = r_cmd_stb;
endmodule
